mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline; sits between the EX/MEM latch and the MEM/WB latch.
- Holds the data memory and performs byte/half/word loads and stores with sign/zero extension.
- Passes write-back control and data through to MEM/WB.
- Contains a memory-dump FSM so the debug unit can stream data memory out over a valid/ready handshake while the pipeline is halted.

Parameters:
DEPTH, 256, data memory size in 32-bit words (power of two)
ADDR_W, 8, word-index width, log2(DEPTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
i_step_enable  in  1  pipeline advance; stores commit only when 1
i_ALU_res  in  32  byte address for loads/stores; also passed through
i_write_data  in  32  store data (rt)
i_addr_reg_dst  in  5  destination register, passed through
i_pc_to_reg  in  32  return PC for JAL/JALR, passed through
is_MemRead  in  1  load enable
is_MemWrite  in  1  store enable
is_mem_size  in  2  00 byte, 01 half, 11 word; 10 treated as word
is_mem_unsigned  in  1  1 = zero-extend loads (LBU/LHU)
is_RegWrite  in  1  passed through
is_MemtoReg  in  1  passed through
is_write_pc  in  1  passed through
i_dump_start  in  1  request a full memory dump
i_dump_ready  in  1  debug unit accepts the current dump word
o_output_mem  out  32  extended load data to MEM/WB
o_ALU_res  out  32  = i_ALU_res
o_addr_reg_dst  out  5  = i_addr_reg_dst
o_pc_to_reg  out  32  = i_pc_to_reg
os_RegWrite  out  1  = is_RegWrite
os_MemtoReg  out  1  = is_MemtoReg
os_write_pc  out  1  = is_write_pc
o_dump_data  out  32  memory word at o_dump_addr
o_dump_addr  out  ADDR_W  current dump word index
o_dump_valid  out  1  dump word valid
o_dump_done  out  1  one-cycle pulse after the last word is accepted
o_misaligned  out  1  sticky misaligned-access flag

Behaviour:
Memory
- Word index = i_ALU_res[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap.
- Read is combinational, so o_output_mem is valid in the same cycle. MEM/WB registers it.
- When is_MemRead=0, o_output_mem = 0.
- Store writes on posedge clk when is_MemWrite & i_step_enable & rst & (FSM not DUMP).
- Store lanes are little-endian:
  - SB: i_write_data[7:0] to byte lane addr[1:0].
  - SH: i_write_data[15:0] to half addr[1].
  - SW: full word.
  - Other lanes are unchanged.
- Load: the byte or half is selected the same way, then sign-extended (is_mem_unsigned=0) or zero-extended.
- A load in the same cycle as a store to the same word returns the old contents.
- Memory contents are not cleared by rst.
- Pass-through outputs are combinational, with no added latency.

Dump FSM (states IDLE, DUMP, DONE)
- IDLE:
  - o_dump_valid=0 and counter=0.
  - i_dump_start & ~i_step_enable moves to DUMP.
  - i_dump_start while i_step_enable=1 is ignored.
- DUMP:
  - o_dump_valid=1, o_dump_addr=counter, o_dump_data=mem[counter].
  - On valid&ready the counter increments.
  - Counter=DEPTH-1 with ready moves to DONE.
  - Without ready, all dump outputs hold.
- DONE: o_dump_done=1 for one cycle, then IDLE with counter=0.
- i_dump_start during DUMP or DONE is ignored.

Reset
- Synchronous, active-low; overrides everything, including a dump in progress.
- Sets FSM=IDLE, counter=0, o_dump_valid=0, o_dump_done=0, o_misaligned=0.
- Sets o_dump_addr=0. o_dump_data shows mem[0] (combinational).
- A store presented in the reset cycle is not written.

Optional Feature:
MEM_MISALIGN_CHECK_EN
- Defined:
  - Misaligned accesses are halfword with addr[0]=1, or word with addr[1:0]≠0.
  - A misaligned store is suppressed.
  - A misaligned load returns 0.
  - o_misaligned goes high the next cycle and stays set until rst.
  - The check applies only while is_MemRead or is_MemWrite is asserted.
- Undefined:
  - Low address bits below the access size are ignored: half uses addr[1]; word ignores addr[1:0].
  - o_misaligned is tied 0.

Test Plan:
1. SW 0x8000_00FF to addr 0x10, then LB/LBU at 0x10 → o_output_mem 0xFFFF_FFFF / 0x0000_00FF. LH at 0x12 → 0xFFFF_8000.
2. SB 0xAB at 0x21 over word 0x1122_3344 → word reads 0x1122_AB44. With i_step_enable=0 the same SB leaves the word unchanged.
3. DEPTH=256, i_step_enable=0, pulse i_dump_start, i_dump_ready toggling every other cycle:
   - 256 words are seen in address order with matching data.
   - o_dump_done pulses exactly once; valid drops.
   - A store attempted during DUMP is not written.
4. Assert rst low mid-dump at addr 0x40 → next cycle o_dump_valid=0, o_dump_addr=0. A fresh dump restarts at 0.
5. SW at 0x0000_0404 (DEPTH=256) → lands in word 1 (wrap). Pass-throughs equal their inputs in the same cycle.
6. MEM_MISALIGN_CHECK_EN defined, SW at 0x13 → memory unchanged, o_misaligned=1 next cycle. Undefined → word 4 written, o_misaligned=0.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage: data memory with byte/half/word load/store, write-back pass-through and a memory-dump FSM.
// Optional build macro MEM_MISALIGN_CHECK_EN enables misaligned-access suppression and a sticky flag.
module mem_stage #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_step_enable,
    input  logic [31:0]       i_ALU_res,
    input  logic [31:0]       i_write_data,
    input  logic [4:0]        i_addr_reg_dst,
    input  logic [31:0]       i_pc_to_reg,
    input  logic              is_MemRead,
    input  logic              is_MemWrite,
    input  logic [1:0]        is_mem_size,
    input  logic              is_mem_unsigned,
    input  logic              is_RegWrite,
    input  logic              is_MemtoReg,
    input  logic              is_write_pc,
    input  logic              i_dump_start,
    input  logic              i_dump_ready,
    output logic [31:0]       o_output_mem,
    output logic [31:0]       o_ALU_res,
    output logic [4:0]        o_addr_reg_dst,
    output logic [31:0]       o_pc_to_reg,
    output logic              os_RegWrite,
    output logic              os_MemtoReg,
    output logic              os_write_pc,
    output logic [31:0]       o_dump_data,
    output logic [ADDR_W-1:0] o_dump_addr,
    output logic              o_dump_valid,
    output logic              o_dump_done,
    output logic              o_misaligned
);

    typedef enum logic [1:0] {S_IDLE, S_DUMP, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [31:0]       mem_q [DEPTH];

    logic [ADDR_W-1:0] idx;
    logic [1:0]        off;
    logic [31:0]       rd_word;
    logic [31:0]       wr_word;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic              access_ok;
    logic              we;

    assign idx     = i_ALU_res[ADDR_W+1:2];
    assign off     = i_ALU_res[1:0];
    assign rd_word = mem_q[idx];

`ifdef MEM_MISALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;
    logic mis;

    always_comb begin
        mis = 1'b0;
        case (is_mem_size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = off[0];
            default: mis = (off != 2'b00);
        endcase
    end

    assign access_ok = ~mis;

    // Sticky until reset; only real accesses can raise it
    always_comb begin
        misaligned_d = misaligned_q;
        if ((is_MemRead | is_MemWrite) & mis) misaligned_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) misaligned_q <= 1'b0;
        else      misaligned_q <= misaligned_d;
    end

    assign o_misaligned = misaligned_q;
`else
    assign access_ok    = 1'b1;
    assign o_misaligned = 1'b0;
`endif

    // Load lane select and extension
    always_comb begin
        byte_sel     = rd_word[{off, 3'b000} +: 8];
        half_sel     = rd_word[{off[1], 4'b0000} +: 16];
        o_output_mem = rd_word;
        case (is_mem_size)
            2'b00: o_output_mem = is_mem_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01: o_output_mem = is_mem_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: o_output_mem = rd_word;
        endcase
        if (!is_MemRead || !access_ok) o_output_mem = 32'd0;
    end

    // Store lane merge: untouched lanes keep their old contents
    always_comb begin
        wr_word = rd_word;
        case (is_mem_size)
            2'b00:   wr_word[{off, 3'b000} +: 8]     = i_write_data[7:0];
            2'b01:   wr_word[{off[1], 4'b0000} +: 16] = i_write_data[15:0];
            default: wr_word = i_write_data;
        endcase
    end

    assign we = is_MemWrite & i_step_enable & rst & (state_q != S_DUMP) & access_ok;

    always_ff @(posedge clk) begin
        if (we) mem_q[idx] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (i_dump_start && !i_step_enable) state_d = S_DUMP;
            end
            S_DUMP: begin
                if (i_dump_ready) begin
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_dump_valid = (state_q == S_DUMP);
    assign o_dump_done  = (state_q == S_DONE);
    assign o_dump_addr  = cnt_q;
    assign o_dump_data  = mem_q[cnt_q];

    assign o_ALU_res      = i_ALU_res;
    assign o_addr_reg_dst = i_addr_reg_dst;
    assign o_pc_to_reg    = i_pc_to_reg;
    assign os_RegWrite    = is_RegWrite;
    assign os_MemtoReg    = is_MemtoReg;
    assign os_write_pc    = is_write_pc;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: loads/stores, lane merging, wrap, dump handshake, reset abort.
module tb_mem_stage;

    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_step_enable;
    logic [31:0]       i_ALU_res;
    logic [31:0]       i_write_data;
    logic [4:0]        i_addr_reg_dst;
    logic [31:0]       i_pc_to_reg;
    logic              is_MemRead;
    logic              is_MemWrite;
    logic [1:0]        is_mem_size;
    logic              is_mem_unsigned;
    logic              is_RegWrite;
    logic              is_MemtoReg;
    logic              is_write_pc;
    logic              i_dump_start;
    logic              i_dump_ready;
    logic [31:0]       o_output_mem;
    logic [31:0]       o_ALU_res;
    logic [4:0]        o_addr_reg_dst;
    logic [31:0]       o_pc_to_reg;
    logic              os_RegWrite;
    logic              os_MemtoReg;
    logic              os_write_pc;
    logic [31:0]       o_dump_data;
    logic [ADDR_W-1:0] o_dump_addr;
    logic              o_dump_valid;
    logic              o_dump_done;
    logic              o_misaligned;

    int checks   = 0;
    int failures = 0;

    mem_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .i_step_enable(i_step_enable),
        .i_ALU_res(i_ALU_res), .i_write_data(i_write_data),
        .i_addr_reg_dst(i_addr_reg_dst), .i_pc_to_reg(i_pc_to_reg),
        .is_MemRead(is_MemRead), .is_MemWrite(is_MemWrite),
        .is_mem_size(is_mem_size), .is_mem_unsigned(is_mem_unsigned),
        .is_RegWrite(is_RegWrite), .is_MemtoReg(is_MemtoReg), .is_write_pc(is_write_pc),
        .i_dump_start(i_dump_start), .i_dump_ready(i_dump_ready),
        .o_output_mem(o_output_mem), .o_ALU_res(o_ALU_res),
        .o_addr_reg_dst(o_addr_reg_dst), .o_pc_to_reg(o_pc_to_reg),
        .os_RegWrite(os_RegWrite), .os_MemtoReg(os_MemtoReg), .os_write_pc(os_write_pc),
        .o_dump_data(o_dump_data), .o_dump_addr(o_dump_addr),
        .o_dump_valid(o_dump_valid), .o_dump_done(o_dump_done),
        .o_misaligned(o_misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {8'hA5, b, ~b, 8'(i * 3)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] size, input logic step);
        @(negedge clk);
        i_ALU_res = addr; i_write_data = data; is_mem_size = size;
        is_MemWrite = 1'b1; i_step_enable = step;
        @(negedge clk);
        is_MemWrite = 1'b0; i_step_enable = 1'b1;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, output logic [31:0] d);
        @(negedge clk);
        i_ALU_res = addr; is_mem_size = size; is_mem_unsigned = uns; is_MemRead = 1'b1;
        #1 d = o_output_mem;
        is_MemRead = 1'b0; is_mem_unsigned = 1'b0;
    endtask

    logic [31:0] d;
    int exp_idx, done_cnt, post, seen;

    initial begin
        rst = 1'b0; i_step_enable = 1'b1; i_ALU_res = '0; i_write_data = '0;
        i_addr_reg_dst = '0; i_pc_to_reg = '0; is_MemRead = 0; is_MemWrite = 0;
        is_mem_size = 2'b11; is_mem_unsigned = 0; is_RegWrite = 0; is_MemtoReg = 0;
        is_write_pc = 0; i_dump_start = 0; i_dump_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 32'(o_dump_valid), 32'd0);
        chk("rst_done", 32'(o_dump_done), 32'd0);
        chk("rst_addr", 32'(o_dump_addr), 32'd0);
        chk("rst_misaligned", 32'(o_misaligned), 32'd0);
        rst = 1'b1;

        // Sign/zero extension
        do_store(32'h10, 32'h8000_00FF, 2'b11, 1'b1);
        do_load(32'h10, 2'b00, 1'b0, d); chk("lb_0x10", d, 32'hFFFF_FFFF);
        do_load(32'h10, 2'b00, 1'b1, d); chk("lbu_0x10", d, 32'h0000_00FF);
        do_load(32'h12, 2'b01, 1'b0, d); chk("lh_0x12", d, 32'hFFFF_8000);
        do_load(32'h12, 2'b01, 1'b1, d); chk("lhu_0x12", d, 32'h0000_8000);
        do_load(32'h10, 2'b11, 1'b0, d); chk("lw_0x10", d, 32'h8000_00FF);
        do_load(32'h13, 2'b00, 1'b1, d); chk("lbu_0x13", d, 32'h0000_0080);
        #1 chk("noread_zero", o_output_mem, 32'd0);

        // Byte/half lane merge and step gating
        do_store(32'h20, 32'h1122_3344, 2'b11, 1'b1);
        do_store(32'h21, 32'h0000_00AB, 2'b00, 1'b1);
        do_load(32'h20, 2'b11, 1'b0, d); chk("sb_merge", d, 32'h1122_AB44);
        do_store(32'h21, 32'h0000_00CD, 2'b00, 1'b0);
        do_load(32'h20, 2'b11, 1'b0, d); chk("sb_nostep", d, 32'h1122_AB44);
        do_store(32'h22, 32'h0000_BEEF, 2'b01, 1'b1);
        do_load(32'h20, 2'b11, 1'b0, d); chk("sh_merge", d, 32'hBEEF_AB44);
        do_load(32'h20, 2'b01, 1'b0, d); chk("lh_0x20", d, 32'hFFFF_AB44);
        do_load(32'h21, 2'b00, 1'b0, d); chk("lb_0x21", d, 32'hFFFF_FFAB);

        // Read during write to the same word sees old data
        do_store(32'h30, 32'h1234_5678, 2'b11, 1'b1);
        @(negedge clk);
        i_ALU_res = 32'h30; is_mem_size = 2'b11; i_write_data = 32'h55;
        is_MemWrite = 1; is_MemRead = 1;
        #1 chk("rdw_old", o_output_mem, 32'h1234_5678);
        @(negedge clk);
        is_MemWrite = 0;
        #1 chk("rdw_new", o_output_mem, 32'h0000_0055);
        is_MemRead = 0;

        // Address wrap and pass-throughs
        do_store(32'h0000_0404, 32'hCAFE_F00D, 2'b11, 1'b1);
        do_load(32'h4, 2'b11, 1'b0, d); chk("wrap_word1", d, 32'hCAFE_F00D);
        @(negedge clk);
        i_ALU_res = 32'hDEAD_0001; i_addr_reg_dst = 5'd19; i_pc_to_reg = 32'h0040_0010;
        is_RegWrite = 1; is_MemtoReg = 0; is_write_pc = 1;
        #1;
        chk("pt_alu", o_ALU_res, 32'hDEAD_0001);
        chk("pt_dst", 32'(o_addr_reg_dst), 32'd19);
        chk("pt_pc", o_pc_to_reg, 32'h0040_0010);
        chk("pt_regwrite", 32'(os_RegWrite), 32'd1);
        chk("pt_memtoreg", 32'(os_MemtoReg), 32'd0);
        chk("pt_writepc", 32'(os_write_pc), 32'd1);
        is_MemtoReg = 1; is_RegWrite = 0;
        #1;
        chk("pt_memtoreg2", 32'(os_MemtoReg), 32'd1);
        chk("pt_regwrite2", 32'(os_RegWrite), 32'd0);

        // Misaligned word store at 0x13
        do_store(32'h13, 32'h1234_5678, 2'b11, 1'b1);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("mis_flag", 32'(o_misaligned), 32'd1);
        do_load(32'h10, 2'b11, 1'b0, d); chk("mis_store_blocked", d, 32'h8000_00FF);
        do_load(32'h11, 2'b01, 1'b1, d); chk("mis_load_zero", d, 32'd0);
        do_load(32'h12, 2'b01, 1'b1, d); chk("aligned_half_ok", d, 32'h0000_8000);
        chk("mis_sticky", 32'(o_misaligned), 32'd1);
`else
        chk("mis_flag", 32'(o_misaligned), 32'd0);
        do_load(32'h10, 2'b11, 1'b0, d); chk("mis_store_written", d, 32'h1234_5678);
        do_load(32'h11, 2'b01, 1'b1, d); chk("half_ignores_a0", d, 32'h0000_5678);
        do_load(32'h13, 2'b11, 1'b0, d); chk("word_ignores_low", d, 32'h1234_5678);
`endif

        // Fill memory with a known pattern
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk);
            i_ALU_res = 32'(i * 4); i_write_data = pat(i); is_mem_size = 2'b11;
            is_MemWrite = 1; i_step_enable = 1;
        end
        @(negedge clk);
        is_MemWrite = 0;

        // Full dump with ready toggling; store attempted mid-dump
        @(negedge clk);
        i_step_enable = 0; i_dump_start = 1;
        @(negedge clk);
        i_dump_start = 0;
        exp_idx = 0; done_cnt = 0; post = 0;
        for (int cyc = 0; cyc < 1200 && post < 4; cyc++) begin
            if (cyc != 0) @(negedge clk);
            i_dump_ready = cyc[0];
            if (cyc == 10) begin
                i_ALU_res = 32'h3FC; i_write_data = 32'h0; is_mem_size = 2'b11;
                is_MemWrite = 1; i_step_enable = 1;
            end
            if (cyc == 13) begin is_MemWrite = 0; i_step_enable = 0; end
            #1;
            if (o_dump_done) done_cnt++;
            if (o_dump_valid && !i_dump_ready) chk("dump_hold_addr", 32'(o_dump_addr), 32'(exp_idx));
            if (o_dump_valid && i_dump_ready) begin
                chk("dump_addr", 32'(o_dump_addr), 32'(exp_idx));
                chk("dump_data", o_dump_data, pat(exp_idx));
                exp_idx++;
            end
            if (done_cnt > 0) post++;
        end
        i_dump_ready = 0;
        chk("dump_count", 32'(exp_idx), 32'(DEPTH));
        chk("dump_done_once", 32'(done_cnt), 32'd1);
        chk("dump_valid_drop", 32'(o_dump_valid), 32'd0);
        do_load(32'h3FC, 2'b11, 1'b0, d); chk("store_blocked_in_dump", d, pat(255));

        // Reset mid-dump at word 0x40, store in reset cycle dropped, then restart
        @(negedge clk);
        i_step_enable = 0; i_dump_start = 1;
        @(negedge clk);
        i_dump_start = 0;
        seen = 0;
        for (int cyc = 0; cyc < 400 && seen == 0; cyc++) begin
            if (cyc != 0) @(negedge clk);
            i_dump_ready = 1;
            #1;
            if (o_dump_valid && o_dump_addr == 8'h40) begin
                seen = 1;
                rst = 0; i_dump_ready = 0;
                i_ALU_res = 32'h8; i_write_data = 32'h0; is_mem_size = 2'b11;
                is_MemWrite = 1; i_step_enable = 1;
            end
        end
        chk("reached_0x40", 32'(seen), 32'd1);
        @(negedge clk);
        #1;
        chk("rst_mid_valid", 32'(o_dump_valid), 32'd0);
        chk("rst_mid_addr", 32'(o_dump_addr), 32'd0);
        chk("rst_mid_data", o_dump_data, pat(0));
        rst = 1; is_MemWrite = 0;
        do_load(32'h8, 2'b11, 1'b0, d); chk("rst_store_blocked", d, pat(2));
        @(negedge clk);
        i_step_enable = 0; i_dump_start = 1;
        @(negedge clk);
        i_dump_start = 0;
        #1;
        chk("restart_valid", 32'(o_dump_valid), 32'd1);
        chk("restart_addr", 32'(o_dump_addr), 32'd0);
        chk("restart_data", o_dump_data, pat(0));
        done_cnt = 0;
        for (int cyc = 0; cyc < 400 && done_cnt == 0; cyc++) begin
            @(negedge clk);
            i_dump_ready = 1;
            #1;
            if (o_dump_done) done_cnt++;
        end
        chk("restart_done", 32'(done_cnt), 32'd1);
        i_dump_ready = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
